dmem_responder: RTL and testbench

- Responder end of the CPU data-memory port: accepts load/store requests over a valid/ready request channel and returns results over a valid/ready response channel.
- Fixed, parameterised access latency.
- Replaces the zero-latency data memory so the core (and later the pipeline/cache work) can be exercised against a stalling memory.
- Doubleword-organised storage, one outstanding transaction.

---
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory port: fixed-latency load/store over valid/ready channels.
// Optional byte-strobe stores are enabled with `define DMEM_RESPONDER_WSTRB_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef DMEM_RESPONDER_WSTRB_EN
  input  logic [7:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [63:0]      addr_q, wdata_q;
  logic [63:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             capture, commit;
  logic             eff_we, legal;
  logic [63:0]      eff_addr, eff_wdata;
  logic [7:0]       eff_strb;
  logic [IDX_W-1:0] idx;

  logic [63:0] mem [DEPTH_WORDS];

  assign capture = (state_q == S_IDLE) && req_valid;

  // In IDLE the live request is used directly, so a LATENCY==1 commit sees it on the accept edge.
  assign eff_we    = (state_q == S_IDLE) ? req_we    : we_q;
  assign eff_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_RESPONDER_WSTRB_EN
  logic [7:0] wstrb_q;

  assign eff_strb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstrb_q <= '0;
    end else if (capture) begin
      wstrb_q <= req_wstrb;
    end
  end
`else
  assign eff_strb = 8'hFF;
`endif

  assign legal = (eff_addr[2:0] == 3'b000) &&
                 ({3'b000, eff_addr[63:3]} < 64'(DEPTH_WORDS));
  assign idx   = eff_addr[IDX_W+2:3];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    rdata_d = (!eff_we && legal) ? mem[idx] : 64'd0;
    err_d   = !legal;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // NOTE: storage is deliberately left out of reset so contents survive it and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit && eff_we && legal) begin
      for (int i = 0; i < 8; i++) begin
        if (eff_strb[i]) begin
          mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed and randomized transactions against a
// word-level reference memory, plus a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid1 = 1'b0, req_we1 = 1'b0, rsp_ready1 = 1'b0;
  logic [63:0] req_addr1 = '0, req_wdata1 = '0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [63:0] rsp_rdata1;

`ifdef DMEM_RESPONDER_WSTRB_EN
  logic [7:0]  req_wstrb = 8'hFF;
`endif

  int checks = 0;
  int errors = 0;

  // Reference storage, indexed by word number; only words the bench has written are ever loaded.
  logic [63:0] model [longint];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_RESPONDER_WSTRB_EN
    .req_wstrb (req_wstrb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_we    (req_we1),
    .req_addr  (req_addr1),
    .req_wdata (req_wdata1),
`ifdef DMEM_RESPONDER_WSTRB_EN
    .req_wstrb (8'hFF),
`endif
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_legal(input logic [63:0] addr);
    return (addr % 8 == 0) && ((addr / 8) < DEPTH);
  endfunction

  // Drives values the responder must ignore while it is busy.
  task automatic drive_garbage();
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
`ifdef DMEM_RESPONDER_WSTRB_EN
    req_wstrb = 8'($urandom);
`endif
  endtask

  // One full transaction starting and ending at a falling edge with the responder idle.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] strb, input int hold);
    logic [63:0] exp_rdata, word;
    logic        exp_err;
    logic [7:0]  s;
    int          k;
`ifdef DMEM_RESPONDER_WSTRB_EN
    s = strb;
`else
    s = strb | 8'hFF;
`endif
    exp_err   = !is_legal(addr);
    exp_rdata = 64'd0;
    if (!exp_err) begin
      if (we) begin
        word = model.exists(longint'(addr / 8)) ? model[longint'(addr / 8)] : 64'hx;
        for (int i = 0; i < 8; i++) if (s[i]) word[8*i +: 8] = wdata[8*i +: 8];
        model[longint'(addr / 8)] = word;
      end else begin
        exp_rdata = model[longint'(addr / 8)];
      end
    end

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
`ifdef DMEM_RESPONDER_WSTRB_EN
    req_wstrb = strb;
`endif
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    drive_garbage();
    k = 1;
    while (!rsp_valid && k < 40) begin
      check("req_ready_wait", 64'(req_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      drive_garbage();
      k++;
    end
    check("latency", 64'(k), 64'(LAT));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); @(negedge clk);
      drive_garbage();
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_ready", 64'(req_ready), 64'd0);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_err", 64'(rsp_err), 64'(exp_err));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", 64'(rsp_valid), 64'd0);
    check("post_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pool [8];
    logic [63:0] a;
    int          kind;

    // Reset state.
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic store then load.
    txn(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
    txn(1'b0, 64'h10, 64'h0, 8'hFF, 0);

    // Faults, then the earlier word is intact.
    txn(1'b0, 64'h13, 64'h0, 8'hFF, 0);
    txn(1'b1, 64'(DEPTH * 8), 64'h1234_5678_9ABC_DEF0, 8'hFF, 0);
    txn(1'b1, 64'h8000_0000_0000_0010, 64'h5555, 8'hFF, 0);
    txn(1'b0, 64'h10, 64'h0, 8'hFF, 0);

    // Back-pressure on the response channel.
    txn(1'b0, 64'h10, 64'h0, 8'hFF, 5);

    // Reset while a store is waiting: the store must not land.
    txn(1'b1, 64'h20, 64'h1111, 8'hFF, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h2222;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check("wait_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("midrst_valid", 64'(rsp_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 64'h20, 64'h0, 8'hFF, 0);

`ifdef DMEM_RESPONDER_WSTRB_EN
    txn(1'b1, 64'h0, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0);
    txn(1'b1, 64'h0, 64'h0, 8'h0F, 0);
    txn(1'b0, 64'h0, 64'h0, 8'hFF, 0);
    txn(1'b1, 64'h0, 64'h0, 8'h00, 0);
    txn(1'b0, 64'h0, 64'h0, 8'hFF, 0);
`endif

    // Randomized traffic over a pool of words initialised first.
    for (int i = 0; i < 8; i++) begin
      pool[i] = 64'($urandom_range(0, DEPTH - 1)) * 8;
      txn(1'b1, pool[i], {$urandom, $urandom}, 8'hFF, 0);
    end
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      a = pool[$urandom_range(0, 7)];
      if (kind == 4) a = a + 64'($urandom_range(1, 7));
      else if (kind == 5) a = 64'(DEPTH * 8) + a;
      txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom),
          $urandom_range(0, 3));
    end

    // LATENCY=1 instance: back-to-back traffic with both valids tied high.
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 64'h8;
    req_wdata1 = 64'hA5A5_0F0F_1234_8765; rsp_ready1 = 1'b1;
    check("l1_idle_ready", 64'(req_ready1), 64'd1);
    @(posedge clk); @(negedge clk);
    check("l1_st_valid", 64'(rsp_valid1), 64'd1);
    check("l1_st_rdata", rsp_rdata1, 64'd0);
    check("l1_st_err", 64'(rsp_err1), 64'd0);
    req_we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("l1_ready", 64'(req_ready1), 64'd1);
      check("l1_gap_valid", 64'(rsp_valid1), 64'd0);
      @(posedge clk); @(negedge clk);
      check("l1_ld_valid", 64'(rsp_valid1), 64'd1);
      check("l1_ld_busy", 64'(req_ready1), 64'd0);
      check("l1_ld_rdata", rsp_rdata1, 64'hA5A5_0F0F_1234_8765);
    end
    req_valid1 = 1'b0;
    rsp_ready1 = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
